// File: rtl/tatsujin_pkg.sv
// Shared constants, types and helpers for the two-lane note track.
`timescale 1ns/1ps
package tatsujin_pkg;

    localparam int LANE_SLOTS = 10;
    localparam int HIT_SLOT   = 0;
    localparam int COUNT_W    = 8;
    localparam int COUNT_MAX  = 255;

    typedef logic [LANE_SLOTS-1:0] lane_t;
    typedef logic [COUNT_W-1:0]    count_t;

    // Adds 0..2 events to a score counter, pinning at COUNT_MAX instead of wrapping.
    function automatic count_t sat_add(input count_t base, input logic [1:0] inc);
        logic [COUNT_W:0] sum;
        sum = {1'b0, base} + {{(COUNT_W-1){1'b0}}, inc};
        if (sum > (COUNT_W+1)'(COUNT_MAX)) begin
            return count_t'(COUNT_MAX);
        end
        return sum[COUNT_W-1:0];
    endfunction

endpackage

// File: rtl/note_track_press_edge.sv
// Rising-edge detector for one player button: a held button yields a single press.
`timescale 1ns/1ps
module press_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic press
);

    logic history;

    // Remember last cycle's button level; sampled even while the track is paused.
    // NOTE: sequential state uses non-blocking (<=) so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            history <= 1'b0;
        end else begin
            history <= level;
        end
    end

    // Cleared history on reset means a button held through reset release counts once.
    assign press = level & ~history;

endmodule

// File: rtl/note_track.sv
// Two-lane (red/yellow) scrolling note track with hit/miss judgement and scoring.
`timescale 1ns/1ps
module note_track
    import tatsujin_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  beat_tick,
    input  logic                  chart_red,
    input  logic                  chart_yellow,
    input  logic                  hit_red,
    input  logic                  hit_yellow,
    output logic [LANE_SLOTS-1:0] red_sequence,
    output logic [LANE_SLOTS-1:0] yellow_sequence,
    output logic [COUNT_W-1:0]    hit_count,
    output logic [COUNT_W-1:0]    miss_count,
    output logic [COUNT_W-1:0]    combo,
    output logic [COUNT_W-1:0]    max_combo,
    output logic                  hit_pulse,
    output logic                  miss_pulse
);

    logic   red_press, yellow_press;
    logic   red_hit, yellow_hit, red_wrong, yellow_wrong;
    logic   red_miss, yellow_miss, beat;
    lane_t  red_kept, yellow_kept, red_next, yellow_next;
    logic [1:0] hits, misses;
    count_t hit_next, miss_next, combo_next, max_next;

    press_edge u_red_edge (
        .clk   (clk),
        .reset (reset),
        .level (hit_red),
        .press (red_press)
    );

    press_edge u_yellow_edge (
        .clk   (clk),
        .reset (reset),
        .level (hit_yellow),
        .press (yellow_press)
    );

    // Judge presses against pre-shift slot 0, then scroll the lanes and score the result.
    // NOTE: every variable gets a default at the top so no path can infer a latch.
    always_comb begin
        red_hit      = 1'b0;
        yellow_hit   = 1'b0;
        red_wrong    = 1'b0;
        yellow_wrong = 1'b0;
        red_miss     = 1'b0;
        yellow_miss  = 1'b0;
        beat         = run & beat_tick;
        red_kept     = red_sequence;
        yellow_kept  = yellow_sequence;

        if (run) begin
            red_hit      = red_press    &  red_sequence[HIT_SLOT];
            red_wrong    = red_press    & ~red_sequence[HIT_SLOT];
            yellow_hit   = yellow_press &  yellow_sequence[HIT_SLOT];
            yellow_wrong = yellow_press & ~yellow_sequence[HIT_SLOT];
        end

        // A note hit this cycle leaves the lane before it can scroll out as a miss.
        if (red_hit)    red_kept[HIT_SLOT]    = 1'b0;
        if (yellow_hit) yellow_kept[HIT_SLOT] = 1'b0;

        red_next    = red_kept;
        yellow_next = yellow_kept;
        if (beat) begin
            red_miss    = red_kept[HIT_SLOT];
            yellow_miss = yellow_kept[HIT_SLOT];
            // Red wins a slot when the chart asks for both colours at once.
            red_next    = {chart_red, red_kept[LANE_SLOTS-1:1]};
            yellow_next = {chart_yellow & ~chart_red, yellow_kept[LANE_SLOTS-1:1]};
        end

        hits   = {1'b0, red_hit}  + {1'b0, yellow_hit};
        misses = {1'b0, red_miss} + {1'b0, yellow_miss};

        hit_next  = sat_add(hit_count, hits);
        miss_next = sat_add(miss_count, misses);
        if (red_wrong || yellow_wrong || red_miss || yellow_miss) begin
            combo_next = '0;
        end else begin
            combo_next = sat_add(combo, hits);
        end
        max_next = (combo_next > max_combo) ? combo_next : max_combo;
    end

    // Register the whole track state and the one-cycle event strobes.
    // NOTE: only control/score flops here, so a synchronous reset of everything is cheap.
    always_ff @(posedge clk) begin
        if (reset) begin
            red_sequence    <= '0;
            yellow_sequence <= '0;
            hit_count       <= '0;
            miss_count      <= '0;
            combo           <= '0;
            max_combo       <= '0;
            hit_pulse       <= 1'b0;
            miss_pulse      <= 1'b0;
        end else begin
            red_sequence    <= red_next;
            yellow_sequence <= yellow_next;
            hit_count       <= hit_next;
            miss_count      <= miss_next;
            combo           <= combo_next;
            max_combo       <= max_next;
            hit_pulse       <= |hits;
            miss_pulse      <= |misses;
        end
    end

endmodule

// File: doc/note_track.md
NOTE_TRACK -- requirements
Module: note_track

Interface
REQ-001 clk  input  1  single system clock (CLOCK_50 domain); all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 run  input  1  level; high = track active, low = paused (state held).
REQ-004 beat_tick  input  1  one-cycle pulse from rate divider; advances track one slot.
REQ-005 chart_red, chart_yellow  input  1 each  note entering slot 9 on beat_tick.
REQ-006 hit_red, hit_yellow  input  1 each  player button levels, active-high (already inverted from KEY).
REQ-007 red_sequence, yellow_sequence  output  10 each  bit i = note in slot i; slot 0 = hit zone; feeds the 10-square renderer.
REQ-008 hit_count, miss_count, combo, max_combo  output  8 each  score counters.
REQ-009 hit_pulse, miss_pulse  output  1 each  one-cycle event strobes for flash effects.

Function
REQ-010 All outputs SHALL be registered; every effect appears on the first rising edge after the causing input cycle.
REQ-011 A press SHALL be a 0->1 transition of hit_red/hit_yellow between consecutive cycles, detected in the edge-detector sub-module; a held button SHALL produce one press only.
REQ-012 A red press with red_sequence[0]=1 SHALL clear red_sequence[0], increment hit_count, increment combo, and assert hit_pulse.
REQ-013 A red press with red_sequence[0]=0 SHALL zero combo and change nothing else; yellow presses SHALL behave identically against yellow_sequence[0].
REQ-014 Red and yellow presses in the same cycle SHALL be judged independently; two hits SHALL add 2 to hit_count and combo.
REQ-015 On beat_tick, each lane SHALL shift toward slot 0: new[8:0]=old[9:1], new[9]=chart bit.
REQ-016 A note shifted out of slot 0 (not hit) SHALL increment miss_count, zero combo, and assert miss_pulse; a red and a yellow shifted out together SHALL add 2 to miss_count.
REQ-017 Press and beat_tick in the same cycle: press SHALL be judged against pre-shift slot 0; a hit note SHALL NOT also count as a miss; the shift SHALL still occur.
REQ-018 chart_red=chart_yellow=1 SHALL load red only (lanes mutually exclusive per slot).
REQ-019 hit_count, miss_count, combo SHALL saturate at 255, never wrap.
REQ-020 max_combo SHALL track max(max_combo, next combo) every cycle.
REQ-021 With run=0, beat_tick and presses SHALL be ignored, all state held; the edge detector SHALL still sample inputs so a button held across resume gives no press.
REQ-022 hit_pulse/miss_pulse SHALL each be high exactly one cycle per qualifying cycle, low otherwise.

Reset
REQ-023 On reset=1 at a clock edge: both sequences 10'b0, all counters 0, pulses 0, edge-detector history 0.
REQ-024 Reset SHALL override run, beat_tick and presses in the same cycle; a press or beat arriving mid-operation with reset high SHALL have no effect.
REQ-025 A button held through reset release SHALL register one press on the first cycle after release.

Structure
REQ-026 Shared package tatsujin_pkg SHALL hold LANE_SLOTS=10, HIT_SLOT=0, COUNT_W=8, COUNT_MAX=255.
REQ-027 One sub-module, press_edge (rising-edge detector with registered history), SHALL be instantiated once per lane; counter saturation stays inline.

Verification
REQ-028 Reset, run=1, chart_red=1 on one beat then 0, 9 further beats -> red_sequence 10'b1000000000 after beat 1, 10'b0000000001 after beat 10.
REQ-029 From red_sequence=10'b0000000001, hit_red 0->1 -> next cycle sequence 0, hit_count=1, combo=1, hit_pulse for one cycle; holding hit_red 20 cycles -> no further change.
REQ-030 From red_sequence=10'b0000000001, combo=5, beat_tick with no press -> miss_count=1, combo=0, max_combo=5, miss_pulse one cycle.
REQ-031 red_sequence[0]=1 and yellow_sequence[0]=0, hit_red and hit_yellow rise together with beat_tick -> hit_count+1, miss_count unchanged, combo=0 (yellow wrong press), lanes shifted.
REQ-032 Force 260 consecutive hits -> hit_count=255, combo=255, max_combo=255, no wrap.
REQ-033 run=0, pulse beat_tick and hit_red -> all outputs unchanged; assert reset with nonzero state -> all outputs 0 next cycle.
